txfifo_wr_arbiter: RTL and testbench

TXFIFO_WR_ARBITER -- requirements
Module: txfifo_wr_arbiter

---
 rtl/txfifo_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_txfifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txfifo_wr_arbiter.sv
// Frame-atomic arbiter granting the TX FIFO write port to the linux or tc requester.
// Optional build macro TXARB_TC_PRIORITY_EN: tc wins every idle tie instead of round-robin.
module txfifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  txfifo_full,
    input  logic                  txfifo_overflow,
    output logic                  txfifo_wr_en,
    output logic [DATA_WIDTH-1:0] txfifo_dwrite,
    input  logic                  linux_req,
    input  logic [DATA_WIDTH-1:0] linux_data,
    input  logic                  linux_last,
    input  logic                  tc_req,
    input  logic [DATA_WIDTH-1:0] tc_data,
    input  logic                  tc_last,
    output logic                  linux_grant,
    output logic                  tc_grant,
    output logic                  linux_ack,
    output logic                  tc_ack,
    output logic                  frame_done,
    output logic                  frame_src,
    output logic [15:0]           word_count,
    output logic                  err_overflow,
    output logic                  err_burst
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, GNT_LINUX, GNT_TC, ACK_GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  src_q, src_d;
    logic                  served_q, served_d;
    logic                  lastw_q, lastw_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] dwrite_q, dwrite_d;
    logic                  gnt_l_q, gnt_l_d;
    logic                  gnt_t_q, gnt_t_d;
    logic                  ack_l_q, ack_l_d;
    logic                  ack_t_q, ack_t_d;
    logic                  done_q, done_d;
    logic                  fsrc_q, fsrc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  eovf_q, eovf_d;
    logic                  eburst_q, eburst_d;
    logic                  tie_tc;
    logic                  sel_tc;

`ifdef TXARB_TC_PRIORITY_EN
    assign tie_tc = 1'b1;
`else
    // served_q: 0 = linux served last, so tc takes the tie
    assign tie_tc = ~served_q;
`endif
    assign sel_tc = tc_req & (~linux_req | tie_tc);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        served_d = served_q;
        lastw_d  = lastw_q;
        wr_en_d  = 1'b0;
        dwrite_d = dwrite_q;
        gnt_l_d  = gnt_l_q;
        gnt_t_d  = gnt_t_q;
        ack_l_d  = 1'b0;
        ack_t_d  = 1'b0;
        done_d   = 1'b0;
        fsrc_d   = fsrc_q;
        cnt_d    = cnt_q;
        eovf_d   = eovf_q | txfifo_overflow;
        eburst_d = eburst_q;
        case (state_q)
            IDLE: begin
                if (linux_req || tc_req) begin
                    src_d   = sel_tc;
                    gnt_t_d = sel_tc;
                    gnt_l_d = ~sel_tc;
                    state_d = sel_tc ? GNT_TC : GNT_LINUX;
                end
            end
            GNT_LINUX: begin
                if (linux_req && !txfifo_full) begin
                    wr_en_d  = 1'b1;
                    dwrite_d = linux_data;
                    ack_l_d  = 1'b1;
                    lastw_d  = linux_last;
                    if (cnt_q < MAX_W) cnt_d = cnt_q + 16'd1;
                    state_d  = ACK_GAP;
                end
            end
            GNT_TC: begin
                if (tc_req && !txfifo_full) begin
                    wr_en_d  = 1'b1;
                    dwrite_d = tc_data;
                    ack_t_d  = 1'b1;
                    lastw_d  = tc_last;
                    if (cnt_q < MAX_W) cnt_d = cnt_q + 16'd1;
                    state_d  = ACK_GAP;
                end
            end
            ACK_GAP: begin
                if (lastw_q) begin
                    state_d = DONE;
                end else if (cnt_q >= MAX_W) begin
                    // Runaway frame: close it without last and flag it
                    state_d  = DONE;
                    eburst_d = 1'b1;
                end else begin
                    state_d = src_q ? GNT_TC : GNT_LINUX;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                fsrc_d   = src_q;
                served_d = src_q;
                gnt_l_d  = 1'b0;
                gnt_t_d  = 1'b0;
                cnt_d    = 16'd0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_q    <= 1'b0;
            served_q <= 1'b0;
            lastw_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            dwrite_q <= '0;
            gnt_l_q  <= 1'b0;
            gnt_t_q  <= 1'b0;
            ack_l_q  <= 1'b0;
            ack_t_q  <= 1'b0;
            done_q   <= 1'b0;
            fsrc_q   <= 1'b0;
            cnt_q    <= 16'd0;
            eovf_q   <= 1'b0;
            eburst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            served_q <= served_d;
            lastw_q  <= lastw_d;
            wr_en_q  <= wr_en_d;
            dwrite_q <= dwrite_d;
            gnt_l_q  <= gnt_l_d;
            gnt_t_q  <= gnt_t_d;
            ack_l_q  <= ack_l_d;
            ack_t_q  <= ack_t_d;
            done_q   <= done_d;
            fsrc_q   <= fsrc_d;
            cnt_q    <= cnt_d;
            eovf_q   <= eovf_d;
            eburst_q <= eburst_d;
        end
    end

    assign txfifo_wr_en  = wr_en_q;
    assign txfifo_dwrite = dwrite_q;
    assign linux_grant   = gnt_l_q;
    assign tc_grant      = gnt_t_q;
    assign linux_ack     = ack_l_q;
    assign tc_ack        = ack_t_q;
    assign frame_done    = done_q;
    assign frame_src     = fsrc_q;
    assign word_count    = cnt_q;
    assign err_overflow  = eovf_q;
    assign err_burst     = eburst_q;

endmodule

// File: tb/tb_txfifo_wr_arbiter.sv
// Bench for txfifo_wr_arbiter: queued frames per requester, predicted write stream from frame-level arbitration rules.
module tb_txfifo_wr_arbiter;

    localparam int DW   = 32;
    localparam int MAXW = 4;
`ifdef TXARB_TC_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          txfifo_full = 1'b0;
    logic          txfifo_overflow = 1'b0;
    logic          txfifo_wr_en;
    logic [DW-1:0] txfifo_dwrite;
    logic          linux_req = 1'b0;
    logic [DW-1:0] linux_data = '0;
    logic          linux_last = 1'b0;
    logic          tc_req = 1'b0;
    logic [DW-1:0] tc_data = '0;
    logic          tc_last = 1'b0;
    logic          linux_grant, tc_grant, linux_ack, tc_ack;
    logic          frame_done, frame_src;
    logic [15:0]   word_count;
    logic          err_overflow, err_burst;

    txfifo_wr_arbiter #(.DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset),
        .txfifo_full(txfifo_full), .txfifo_overflow(txfifo_overflow),
        .txfifo_wr_en(txfifo_wr_en), .txfifo_dwrite(txfifo_dwrite),
        .linux_req(linux_req), .linux_data(linux_data), .linux_last(linux_last),
        .tc_req(tc_req), .tc_data(tc_data), .tc_last(tc_last),
        .linux_grant(linux_grant), .tc_grant(tc_grant),
        .linux_ack(linux_ack), .tc_ack(tc_ack),
        .frame_done(frame_done), .frame_src(frame_src), .word_count(word_count),
        .err_overflow(err_overflow), .err_burst(err_burst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    word_t         lq[$];
    word_t         tq[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_src[$];
    int            exp_cnt[$];
    bit            exp_fsrc[$];
    bit            m_last, m_burst, m_ovf;
    int            g_first;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input bit to_tc, input logic [DW-1:0] d, input bit last);
        word_t w;
        w.d = d;
        w.last = last;
        if (to_tc) tq.push_back(w);
        else lq.push_back(w);
    endtask

    task automatic add_frame(input bit to_tc, input int len, input bit with_last);
        for (int i = 0; i < len; i++)
            add_word(to_tc, $urandom, with_last && (i == len - 1));
    endtask

    // Frame-level reference: whole frames (cut at last or at MAXW words) handed out by tie rule.
    task automatic model_build();
        word_t l[$];
        word_t t[$];
        word_t w;
        bit    pick, closed, fin;
        int    n;
        l = lq;
        t = tq;
        while (l.size() > 0 || t.size() > 0) begin
            if (l.size() > 0 && t.size() > 0) pick = PRIO ? 1'b1 : (m_last == 1'b0);
            else pick = (t.size() > 0);
            n = 0;
            closed = 1'b0;
            fin = 1'b0;
            while (!closed) begin
                w = pick ? t.pop_front() : l.pop_front();
                n++;
                exp_data.push_back(w.d);
                exp_src.push_back(pick);
                exp_cnt.push_back(n);
                if (w.last) begin
                    closed = 1'b1;
                    fin = 1'b1;
                end else if (n == MAXW) begin
                    closed = 1'b1;
                    fin = 1'b1;
                    m_burst = 1'b1;
                end else if ((pick ? t.size() : l.size()) == 0) begin
                    closed = 1'b1;
                end
            end
            if (fin) begin
                exp_fsrc.push_back(pick);
                m_last = pick;
            end
        end
    endtask

    task automatic drive_reqs();
        linux_req  = (lq.size() > 0);
        linux_data = (lq.size() > 0) ? lq[0].d : '0;
        linux_last = (lq.size() > 0) ? lq[0].last : 1'b0;
        tc_req     = (tq.size() > 0);
        tc_data    = (tq.size() > 0) ? tq[0].d : '0;
        tc_last    = (tq.size() > 0) ? tq[0].last : 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        txfifo_full = 1'b0;
        txfifo_overflow = 1'b0;
        lq.delete();
        tq.delete();
        exp_data.delete();
        exp_src.delete();
        exp_cnt.delete();
        exp_fsrc.delete();
        m_last = 1'b0;
        m_burst = 1'b0;
        m_ovf = 1'b0;
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", txfifo_wr_en, 0);
        chk("rst_dwrite", txfifo_dwrite, 0);
        chk("rst_grants", {linux_grant, tc_grant}, 0);
        chk("rst_acks", {linux_ack, tc_ack}, 0);
        chk("rst_done", {frame_done, frame_src}, 0);
        chk("rst_count", word_count, 0);
        chk("rst_errs", {err_overflow, err_burst}, 0);
        reset = 1'b0;
    endtask

    // full_mode: 0 never full, 1 random, 2 a 10-cycle stall early in the run
    task automatic run(input int full_mode, input int stop_writes);
        int cyc, writes, idle;
        bit fin;
        model_build();
        drive_reqs();
        g_first = -1;
        cyc = 0;
        writes = 0;
        idle = 0;
        fin = 1'b0;
        while (!fin && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (g_first < 0 && (linux_grant || tc_grant)) g_first = cyc;
            chk("grant_excl", linux_grant & tc_grant, 0);
            chk("ack_excl", linux_ack & tc_ack, 0);
            chk("ack_vs_wr", linux_ack | tc_ack, txfifo_wr_en);
            if (txfifo_full) chk("wr_when_full", txfifo_wr_en, 0);
            if (txfifo_wr_en) begin
                writes++;
                if (exp_data.size() == 0) chk("spurious_wr", txfifo_wr_en, 0);
                else begin
                    chk("wr_src", tc_ack, exp_src.pop_front());
                    chk("wr_data", txfifo_dwrite, exp_data.pop_front());
                    chk("word_count", word_count, exp_cnt.pop_front());
                    chk("owner_grant", tc_ack ? tc_grant : linux_grant, 1);
                end
            end
            if (frame_done) begin
                if (exp_fsrc.size() == 0) chk("spurious_done", frame_done, 0);
                else begin
                    chk("frame_src", frame_src, exp_fsrc.pop_front());
                    chk("done_count", word_count, 0);
                end
            end
            if (stop_writes > 0 && writes == stop_writes) return;
            if (linux_ack && lq.size() > 0) void'(lq.pop_front());
            if (tc_ack && tq.size() > 0) void'(tq.pop_front());
            drive_reqs();
            case (full_mode)
                1:       txfifo_full = ($urandom_range(0, 2) == 0);
                2:       txfifo_full = (cyc >= 3 && cyc < 13);
                default: txfifo_full = 1'b0;
            endcase
            if (lq.size() == 0 && tq.size() == 0 && exp_data.size() == 0 && exp_fsrc.size() == 0)
                idle++;
            if (idle >= 6) fin = 1'b1;
        end
        txfifo_full = 1'b0;
        chk("run_timeout", fin, 1);
        chk("err_burst", err_burst, m_burst);
        chk("err_overflow", err_overflow, m_ovf);
    endtask

    initial begin
        do_reset();

        // single linux word
        add_word(1'b0, 32'hA5A5A5A5, 1'b1);
        run(0, 0);
        chk("grant_latency", g_first, 1);

        // tie after reset: tc frame first
        do_reset();
        add_frame(1'b0, 2, 1'b1);
        add_frame(1'b1, 2, 1'b1);
        run(0, 0);

        // back-pressure mid-frame
        add_frame(1'b0, 4, 1'b1);
        add_frame(1'b1, 3, 1'b1);
        run(2, 0);

        // burst limit: tc streams 6 words without last, linux waiting
        do_reset();
        add_frame(1'b1, 6, 1'b0);
        add_frame(1'b0, 2, 1'b1);
        run(0, 0);
        chk("burst_flag", err_burst, 1);

        // reset in the middle of a 5-word frame
        do_reset();
        add_frame(1'b0, 5, 1'b1);
        run(0, 2);
        do_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", frame_done, 0);
            chk("no_ack_after_rst", linux_ack | tc_ack, 0);
        end
        add_frame(1'b0, 2, 1'b1);
        add_frame(1'b1, 2, 1'b1);
        run(0, 0);

        // overflow pulse is sticky
        txfifo_overflow = 1'b1;
        @(posedge clk);
        #1;
        txfifo_overflow = 1'b0;
        m_ovf = 1'b1;
        chk("ovf_set", err_overflow, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovf_sticky", err_overflow, 1);

        // three rounds of ties
        for (int i = 0; i < 3; i++) begin
            add_frame(1'b0, 1 + (i % 2), 1'b1);
            add_frame(1'b1, 2 - (i % 2), 1'b1);
        end
        run(0, 0);

        // randomized frame mixes with random back-pressure
        for (int r = 0; r < 20; r++) begin
            int nl, nt;
            nl = $urandom_range(0, 3);
            nt = $urandom_range(0, 3);
            for (int f = 0; f < nl; f++) add_frame(1'b0, $urandom_range(1, MAXW), 1'b1);
            for (int f = 0; f < nt; f++) add_frame(1'b1, $urandom_range(1, MAXW), 1'b1);
            run($urandom_range(0, 1), 0);
        end

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
